// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the shared regfile write port
// plus the per-register busy scoreboard used by decode.
module rf_wb_arbiter #(
  parameter int unsigned W       = 31,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src0_valid,
  output logic         src0_ready,
  input  logic [4:0]   src0_addr,
  input  logic [W:0]   src0_data,
  input  logic         src1_valid,
  output logic         src1_ready,
  input  logic [4:0]   src1_addr,
  input  logic [W:0]   src1_data,
  input  logic         sb_set_en,
  input  logic [4:0]   sb_set_addr,
  input  logic [4:0]   q_addr1,
  input  logic [4:0]   q_addr2,
  output logic         q_busy1,
  output logic         q_busy2,
  output logic         rf_wen,
  output logic [4:0]   rf_wadd,
  output logic [W:0]   rf_wdata,
  output logic [31:0]  busy_vec
);

  logic        ptr_q, ptr_d;
  logic        wen_q, wen_d;
  logic [4:0]  wadd_q, wadd_d;
  logic [W:0]  wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;
  logic        gnt0, gnt1;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt0 = src0_valid && (!src1_valid || !ptr_q);
    gnt1 = src1_valid && (!src0_valid || ptr_q);
  end

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;

  // Next state for pointer, write port register and scoreboard.
  always_comb begin
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    wadd_d  = wadd_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    if (gnt0) begin
      ptr_d   = 1'b1;
      wen_d   = (src0_addr != 5'd0);
      wadd_d  = src0_addr;
      wdata_d = src0_data;
    end else if (gnt1) begin
      ptr_d   = 1'b0;
      wen_d   = (src1_addr != 5'd0);
      wadd_d  = src1_addr;
      wdata_d = src1_data;
    end
    // Clear on the regfile write edge; a fresh set overrides it.
    if (wen_q) busy_d[wadd_q] = 1'b0;
    if (sb_set_en) busy_d[sb_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= RR_INIT;
      wen_q   <= 1'b0;
      wadd_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      wadd_q  <= wadd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_wadd  = wadd_q;
  assign rf_wdata = wdata_q;
  assign busy_vec = busy_q;
  assign q_busy1  = busy_q[q_addr1];
  assign q_busy2  = busy_q[q_addr2];

endmodule
